level_tile_loader: RTL and testbench
====================================

LEVEL_TILE_LOADER -- requirements
Module: level_tile_loader

Interface
REQ-001 SHALL have parameter TILE_W, default 8, tile code width in bits.
REQ-002 SHALL have parameter GOAL_CODE, default 8'h03, tile code counted as goal.
REQ-003 Clk  input  1  system clock; all logic on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  load request, level-sensitive; a rising edge requests a load.
REQ-006 level_sel  input  3  level number to load; sampled at load begin.
REQ-007 rom_addr  output  9  level ROM address {level, index[5:0]}.
REQ-008 rom_data  input  TILE_W  level ROM read data, valid one Clk after rom_addr.
REQ-009 ram_we  output  1  tile RAM write strobe.
REQ-010 ram_addr  output  6  tile RAM write address.
REQ-011 ram_wdata  output  TILE_W  tile RAM write data.
REQ-012 busy  output  1  high from load begin through last write.
REQ-013 done  output  1  one-cycle pulse after a load completes.
REQ-014 goal_count  output  7  number of GOAL_CODE tiles in last completed load.

Function
REQ-015 SHALL detect start rising edges internally (registered previous value); a held-high start SHALL produce one request.
REQ-016 SHALL implement FSM states IDLE, PRIME, COPY, FINISH.
REQ-017 IDLE -> PRIME on request (edge or pending); level_sel latched into lvl_q; rom_addr = {level_sel, 6'd0}.
REQ-018 PRIME: one cycle; busy=1, ram_we=0; next state COPY with index k=0.
REQ-019 COPY cycle k (0..63): ram_we=1, ram_addr=k, ram_wdata=rom_data, rom_addr={lvl_q, k+1 mod 64}.
REQ-020 COPY -> FINISH after k=63 write; exactly 64 writes per load, addresses 0..63 ascending, no gaps.
REQ-021 FINISH: one cycle; busy=0, ram_we=0, done=1, goal_count updated; next IDLE.
REQ-022 Latency: first ram_we two cycles after the cycle the edge is registered; done 66 cycles after load begin.
REQ-023 Goal counter SHALL reset to 0 at PRIME, increment in COPY when rom_data==GOAL_CODE; 7 bits, 64 max, no overflow.
REQ-024 goal_count output SHALL hold previous load's value until FINISH, then the new total.
REQ-025 Start edge during PRIME/COPY/FINISH SHALL set a single pending flag; further edges while pending SHALL be dropped.
REQ-026 Pending flag SHALL be serviced from IDLE on the cycle after FINISH, sampling level_sel at that time; flag cleared then.
REQ-027 Start edge coinciding with FINISH SHALL set pending (not be lost).
REQ-028 ram_we SHALL be 0 in every state other than COPY; ram_addr/ram_wdata don't-care when ram_we=0 but registered.
REQ-029 level_sel changes during a load SHALL not affect the in-progress load.

Reset
REQ-030 Reset SHALL force IDLE, and busy=0, done=0, ram_we=0, ram_addr=0, ram_wdata=0, rom_addr=0, goal_count=0, pending=0, edge register=0.
REQ-031 Reset mid-load SHALL abort immediately; no further writes; no done pulse; partial RAM contents left as written.
REQ-032 After Reset release with start already high, no load SHALL begin until start falls and rises again.

Structure
REQ-033 Shared package level_pkg SHALL hold NUM_TILES=64, TILE_IDX_W=6, LEVEL_W=3, GOAL_CODE default, and the FSM state enum.
REQ-034 One sub-module rise_detect (async reset, 1-bit registered edge pulse) SHALL be used for start.
REQ-035 All outputs SHALL be registered.

Verification
REQ-036 Reset, level_sel=2, start 0->1 -> 64 writes ram_addr 0..63, rom_addr {2,k}, done one pulse at cycle 66, busy low after.
REQ-037 ROM model with GOAL_CODE at indices 5,17,63 -> goal_count=3 after done; prior value held during load.
REQ-038 Second start edge at COPY k=20 with level_sel=4 -> first load completes unchanged, second load of level 4 begins cycle after FINISH.
REQ-039 Three start edges during one load -> exactly two loads total.
REQ-040 Reset asserted at COPY k=30 -> ram_we low next edge, no done, goal_count=0; start held high through release -> no load.
REQ-041 start held high 200 cycles -> exactly one load; level_sel toggled mid-load -> rom_addr level bits constant.

Source files
------------

// File: rtl/level_pkg.sv
// Shared constants and FSM encoding for the level tile loader.
package level_pkg;

    localparam int NUM_TILES  = 64;
    localparam int TILE_IDX_W = 6;
    localparam int LEVEL_W    = 3;

    localparam logic [7:0] GOAL_CODE_DEFAULT = 8'h03;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_COPY   = 2'd2,
        ST_FINISH = 2'd3
    } load_state_t;

endpackage

// File: rtl/level_tile_loader_rise_detect.sv
// Registered rising-edge pulse. The detector re-arms only after sig has been
// seen low, so a level held high across reset never fires a pulse.
module rise_detect (
    input  logic Clk,
    input  logic Reset,
    input  logic sig,
    output logic pulse
);

    logic prev_q;
    logic armed_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            prev_q  <= sig;
            armed_q <= armed_q | ~sig;
            pulse   <= sig & ~prev_q & armed_q;
        end
    end

endmodule

// File: rtl/level_tile_loader.sv
// Copies one 64-tile level from the level ROM into tile RAM on a start edge,
// counting goal tiles; one further request may be queued while busy.
module level_tile_loader
    import level_pkg::*;
#(
    parameter int                TILE_W    = 8,
    parameter logic [TILE_W-1:0] GOAL_CODE = TILE_W'(GOAL_CODE_DEFAULT)
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          start,
    input  logic [LEVEL_W-1:0]            level_sel,
    output logic [LEVEL_W+TILE_IDX_W-1:0] rom_addr,
    input  logic [TILE_W-1:0]             rom_data,
    output logic                          ram_we,
    output logic [TILE_IDX_W-1:0]         ram_addr,
    output logic [TILE_W-1:0]             ram_wdata,
    output logic                          busy,
    output logic                          done,
    output logic [6:0]                    goal_count
);

    load_state_t          state_q;
    logic [LEVEL_W-1:0]   lvl_q;
    logic                 pending_q;
    logic [6:0]           goal_cnt_q;
    logic                 start_pulse;
    logic                 goal_hit;
    logic [TILE_IDX_W-1:0] rd_idx_next;

    rise_detect u_start_edge (
        .Clk   (Clk),
        .Reset (Reset),
        .sig   (start),
        .pulse (start_pulse)
    );

    // The tile being written this cycle is the one that counts toward the goal total.
    assign goal_hit    = (ram_wdata == GOAL_CODE);
    assign rd_idx_next = rom_addr[TILE_IDX_W-1:0] + TILE_IDX_W'(1);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            lvl_q      <= '0;
            pending_q  <= 1'b0;
            goal_cnt_q <= '0;
            rom_addr   <= '0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            goal_count <= '0;
        end else begin
            done <= 1'b0;

            // Only one request can be queued; later edges while queued are dropped.
            if (state_q != ST_IDLE && start_pulse)
                pending_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (start_pulse || pending_q) begin
                        state_q   <= ST_PRIME;
                        pending_q <= 1'b0;
                        lvl_q     <= level_sel;
                        rom_addr  <= {level_sel, {TILE_IDX_W{1'b0}}};
                        busy      <= 1'b1;
                    end
                end
                ST_PRIME: begin
                    state_q    <= ST_COPY;
                    goal_cnt_q <= '0;
                    ram_we     <= 1'b1;
                    ram_addr   <= '0;
                    ram_wdata  <= rom_data;
                    rom_addr   <= {lvl_q, rd_idx_next};
                end
                ST_COPY: begin
                    goal_cnt_q <= goal_cnt_q + {6'd0, goal_hit};
                    if (ram_addr == TILE_IDX_W'(NUM_TILES - 1)) begin
                        state_q    <= ST_FINISH;
                        ram_we     <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        goal_count <= goal_cnt_q + {6'd0, goal_hit};
                    end else begin
                        ram_addr  <= ram_addr + TILE_IDX_W'(1);
                        ram_wdata <= rom_data;
                        rom_addr  <= {lvl_q, rd_idx_next};
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_level_tile_loader.sv
// Self-checking bench: random level ROM, write-stream monitor against an
// expected-load queue, and directed scenarios for latency, queuing and reset.
module tb_level_tile_loader;

    localparam int         TILE_W = 8;
    localparam logic [7:0] GOAL   = 8'h03;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  level_sel = 3'd0;
    logic [8:0]  rom_addr;
    logic [7:0]  rom_data;
    logic        ram_we;
    logic [5:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic        busy;
    logic        done;
    logic [6:0]  goal_count;

    level_tile_loader #(
        .TILE_W    (TILE_W),
        .GOAL_CODE (GOAL)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .start      (start),
        .level_sel  (level_sel),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .busy       (busy),
        .done       (done),
        .goal_count (goal_count)
    );

    always #5 Clk = ~Clk;

    // Level ROM: data for an address is available by the next clock edge.
    logic [7:0] rom [0:511];
    assign rom_data = rom[rom_addr];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_goal(input logic [2:0] lvl);
        int cnt = 0;
        for (int i = 0; i < 64; i++)
            if (rom[{lvl, 6'(i)}] == GOAL) cnt++;
        return cnt;
    endfunction

    // Write-stream monitor: each load must be 64 ascending writes of its level's ROM.
    int          wr_idx = 0;
    int          loads_done = 0;
    int          prev_goal = 0;
    logic [2:0]  cur_lvl = 3'd0;
    logic [5:0]  i6;
    logic        done_d = 1'b0;
    int          exp_lvls[$];

    always @(negedge Clk) begin
        if (Reset) begin
            wr_idx    = 0;
            prev_goal = 0;
            done_d    = 1'b0;
        end else begin
            if (ram_we) begin
                if (wr_idx == 0) begin
                    check("load_expected", 32'(exp_lvls.size() > 0), 1);
                    if (exp_lvls.size() > 0) cur_lvl = 3'(exp_lvls.pop_front());
                end
                i6 = 6'(wr_idx);
                check("ram_addr", 32'(ram_addr), wr_idx);
                check("ram_wdata", 32'(ram_wdata), 32'(rom[{cur_lvl, i6}]));
                check("rom_addr", 32'(rom_addr), 32'({cur_lvl, 6'(i6 + 6'd1)}));
                check("busy_in_copy", 32'(busy), 1);
                check("goal_hold", 32'(goal_count), prev_goal);
                wr_idx++;
            end
            if (done) begin
                check("done_single", 32'(done_d), 0);
                check("done_writes", wr_idx, 64);
                check("goal_count", 32'(goal_count), model_goal(cur_lvl));
                check("busy_at_done", 32'(busy), 0);
                prev_goal = model_goal(cur_lvl);
                wr_idx    = 0;
                loads_done++;
            end
            done_d = done;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge Clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic wait_write(input int k, input int budget);
        int found = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (ram_we && ram_addr == 6'(k)) begin
                found = 1;
                break;
            end
        end
        check("reach_write_k", found, 1);
    endtask

    task automatic wait_done(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int we_at, done_at, n, l0, lv, nl, extra;

        for (int a = 0; a < 512; a++) begin
            logic [7:0] v;
            v = 8'($urandom_range(0, 255));
            if (v == GOAL) v = 8'h04;
            if ($urandom_range(0, 7) == 0) v = GOAL;
            rom[a] = v;
        end
        for (int i = 0; i < 64; i++)
            if (rom[{3'd5, 6'(i)}] == GOAL) rom[{3'd5, 6'(i)}] = 8'h55;
        rom[{3'd5, 6'd5}]  = GOAL;
        rom[{3'd5, 6'd17}] = GOAL;
        rom[{3'd5, 6'd63}] = GOAL;

        // Reset values
        tick(3);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_ram_wdata", 32'(ram_wdata), 0);
        check("rst_rom_addr", 32'(rom_addr), 0);
        check("rst_goal_count", 32'(goal_count), 0);
        Reset = 1'b0;
        tick(3);

        // Basic load of level 2 with latency measurement
        level_sel = 3'd2;
        exp_lvls.push_back(2);
        start = 1'b1;
        we_at = -1;
        done_at = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge Clk);
            #2;
            if (ram_we && we_at < 0) we_at = i;
            if (done) begin
                done_at = i;
                break;
            end
        end
        check("first_we_latency", we_at, 3);
        check("done_latency", done_at, 67);
        tick();
        check("busy_after_done", 32'(busy), 0);
        check("done_pulse_width", 32'(done), 0);
        start = 1'b0;
        tick(3);

        // Level 5 with goals at 5, 17, 63
        level_sel = 3'd5;
        exp_lvls.push_back(5);
        pulse_start();
        wait_done(200, n);
        check("done_seen_l5", 32'(n > 0), 1);
        check("goal_l5", 32'(goal_count), 3);
        tick(3);

        // Edge at k=20 with new level queues a second load
        l0 = loads_done;
        level_sel = 3'd1;
        exp_lvls.push_back(1);
        pulse_start();
        wait_write(20, 100);
        level_sel = 3'd4;
        exp_lvls.push_back(4);
        pulse_start();
        wait_done(200, n);
        check("done_seen_first", 32'(n > 0), 1);
        we_at = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (ram_we) begin
                we_at = i;
                break;
            end
        end
        check("pending_we_latency", we_at, 3);
        wait_done(200, n);
        check("done_seen_pending", 32'(n > 0), 1);
        tick(5);
        check("queued_two_loads", loads_done - l0, 2);

        // Three edges during one load give exactly two loads
        l0 = loads_done;
        level_sel = 3'd6;
        exp_lvls.push_back(6);
        exp_lvls.push_back(3);
        pulse_start();
        tick(5);
        level_sel = 3'd3;
        repeat (3) begin
            pulse_start();
            tick(4);
        end
        wait_done(200, n);
        wait_done(200, n);
        tick(100);
        check("three_edges_two_loads", loads_done - l0, 2);
        check("queue_drained_a", exp_lvls.size(), 0);

        // start held high with level_sel toggling mid-load
        l0 = loads_done;
        level_sel = 3'd7;
        exp_lvls.push_back(7);
        start = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (i == 30) level_sel = 3'd0;
            if (i == 50) level_sel = 3'd6;
        end
        start = 1'b0;
        tick(5);
        check("held_start_one_load", loads_done - l0, 1);

        // Reset at k=30, start held high through release
        l0 = loads_done;
        level_sel = 3'd0;
        exp_lvls.push_back(0);
        start = 1'b1;
        wait_write(30, 100);
        Reset = 1'b1;
        #1;
        check("abort_ram_we", 32'(ram_we), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_goal", 32'(goal_count), 0);
        tick(2);
        Reset = 1'b0;
        tick(150);
        check("no_load_after_reset", loads_done - l0, 0);
        check("no_write_after_reset", wr_idx, 0);
        check("goal_after_abort", 32'(goal_count), 0);
        start = 1'b0;
        tick(2);
        level_sel = 3'd3;
        exp_lvls.push_back(3);
        pulse_start();
        wait_done(200, n);
        check("load_after_rearm", 32'(n > 0), 1);
        tick(3);

        // Randomized loads with 0..2 extra edges during each
        for (int it = 0; it < 5; it++) begin
            l0 = loads_done;
            lv = $urandom_range(0, 7);
            level_sel = 3'(lv);
            exp_lvls.push_back(lv);
            pulse_start();
            extra = $urandom_range(0, 2);
            for (int e = 0; e < extra; e++) begin
                tick($urandom_range(2, 15));
                nl = $urandom_range(0, 7);
                level_sel = 3'(nl);
                pulse_start();
            end
            if (extra > 0) exp_lvls.push_back(int'(level_sel));
            wait_done(200, n);
            if (extra > 0) wait_done(200, n);
            tick(4);
            check("rand_load_count", loads_done - l0, (extra > 0) ? 2 : 1);
        end

        check("queue_drained_end", exp_lvls.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
